// File: rtl/vga_fbuff_wr_ctrl.sv
// Port-A owner of vga_frame_buffer: serves line-buffer row reads at priority and
// applies host tile writes as read-modify-write on the packed frame-buffer row.
module vga_fbuff_wr_ctrl #(
  parameter int PXL_WIDTH        = 12,
  parameter int TILE_PER_ROW     = 4,
  parameter int TILE_PER_LINE    = 160,
  parameter int TILE_LINES       = 120,
  parameter int FBUFF_DATA_WIDTH = 48,
  parameter int FBUFF_ADDR_WIDTH = 13,
  parameter int FBUFF_LATENCY    = 1,
  parameter int TX_WIDTH         = 8,
  parameter int TY_WIDTH         = 7
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic                        wr_valid_i,
  output logic                        wr_ready_o,
  input  logic [TX_WIDTH-1:0]         wr_tile_x_i,
  input  logic [TY_WIDTH-1:0]         wr_tile_y_i,
  input  logic [PXL_WIDTH-1:0]        wr_colr_i,
  output logic                        wr_err_o,
  input  logic                        lb_rd_req_i,
  input  logic [FBUFF_ADDR_WIDTH-1:0] lb_addr_i,
  output logic                        lb_rd_rsp_o,
  output logic [FBUFF_DATA_WIDTH-1:0] lb_data_o,
  output logic [FBUFF_ADDR_WIDTH-1:0] fbuff_addr_o,
  output logic                        fbuff_en_o,
  output logic                        fbuff_wen_o,
  output logic [FBUFF_DATA_WIDTH-1:0] fbuff_data_o,
  input  logic [FBUFF_DATA_WIDTH-1:0] fbuff_data_i
);

  localparam int ROWS_PER_LINE = TILE_PER_LINE / TILE_PER_ROW;
  localparam int SLOT_W        = (TILE_PER_ROW > 1) ? $clog2(TILE_PER_ROW) : 1;
  localparam int CNT_W         = (FBUFF_LATENCY > 1) ? $clog2(FBUFF_LATENCY) : 1;
  localparam int PROD_W        = FBUFF_ADDR_WIDTH + 1;

  localparam logic [CNT_W-1:0]  LAT_LAST = CNT_W'(FBUFF_LATENCY - 1);
  localparam logic [TX_WIDTH:0] X_LIM    = (TX_WIDTH + 1)'(TILE_PER_LINE);
  localparam logic [TY_WIDTH:0] Y_LIM    = (TY_WIDTH + 1)'(TILE_LINES);

  typedef enum logic [2:0] {
    IDLE,
    LB_WAIT,
    RMW_RD,
    RMW_WAIT,
    RMW_WR
  } state_t;

  state_t                      state;
  state_t                      state_nxt;
  logic [CNT_W-1:0]            lat_cnt;
  logic                        lat_last;
  logic [TX_WIDTH-1:0]         x_q;
  logic [TY_WIDTH-1:0]         y_q;
  logic [PXL_WIDTH-1:0]        colr_q;
  logic [FBUFF_DATA_WIDTH-1:0] rmw_q;
  logic [FBUFF_DATA_WIDTH-1:0] merged;
  logic                        err_q;
  logic                        in_range;
  logic                        accept;
  logic [PROD_W-1:0]           row_wide;
  logic [FBUFF_ADDR_WIDTH-1:0] row;
  logic [SLOT_W-1:0]           slot;

  assign in_range = ({1'b0, wr_tile_x_i} < X_LIM) && ({1'b0, wr_tile_y_i} < Y_LIM);
  assign accept   = rstn && (state == IDLE) && !lb_rd_req_i && wr_valid_i;
  assign lat_last = (lat_cnt == LAT_LAST);

  // Row product is formed one bit wider than the address before truncation.
  assign row_wide = PROD_W'(y_q) * PROD_W'(ROWS_PER_LINE) + PROD_W'(x_q / TILE_PER_ROW);
  assign row      = FBUFF_ADDR_WIDTH'(row_wide);
  assign slot     = SLOT_W'(x_q % TILE_PER_ROW);

  always_comb begin
    merged = fbuff_data_i;
    merged[slot*PXL_WIDTH +: PXL_WIDTH] = colr_q;
  end

  assign lb_data_o    = fbuff_data_i;
  assign fbuff_data_o = rmw_q;
  assign wr_err_o     = err_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // IDLE outputs are gated by rstn so ready/enable are low while reset is held.
  always_comb begin
    state_nxt    = state;
    wr_ready_o   = 1'b0;
    lb_rd_rsp_o  = 1'b0;
    fbuff_en_o   = 1'b0;
    fbuff_wen_o  = 1'b0;
    fbuff_addr_o = '0;
    case (state)
      IDLE: begin
        if (rstn) begin
          if (lb_rd_req_i) begin
            fbuff_en_o   = 1'b1;
            fbuff_addr_o = lb_addr_i;
            state_nxt    = LB_WAIT;
          end else begin
            wr_ready_o = 1'b1;
            if (wr_valid_i && in_range) begin
              state_nxt = RMW_RD;
            end
          end
        end
      end
      LB_WAIT: begin
        if (lat_last) begin
          lb_rd_rsp_o = 1'b1;
          state_nxt   = IDLE;
        end
      end
      RMW_RD: begin
        fbuff_en_o   = 1'b1;
        fbuff_addr_o = row;
        state_nxt    = RMW_WAIT;
      end
      RMW_WAIT: begin
        if (lat_last) begin
          state_nxt = RMW_WR;
        end
      end
      RMW_WR: begin
        fbuff_en_o   = 1'b1;
        fbuff_wen_o  = 1'b1;
        fbuff_addr_o = row;
        state_nxt    = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      lat_cnt <= '0;
    end else if ((state == LB_WAIT) || (state == RMW_WAIT)) begin
      lat_cnt <= lat_last ? '0 : lat_cnt + 1'b1;
    end else begin
      lat_cnt <= '0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      x_q    <= '0;
      y_q    <= '0;
      colr_q <= '0;
      err_q  <= 1'b0;
    end else begin
      err_q <= accept && !in_range;
      if (accept) begin
        x_q    <= wr_tile_x_i;
        y_q    <= wr_tile_y_i;
        colr_q <= wr_colr_i;
      end
    end
  end

  // rmw_q keeps the merged row, so the write data holds after the sequence ends.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rmw_q <= '0;
    end else if ((state == RMW_WAIT) && lat_last) begin
      rmw_q <= merged;
    end
  end

endmodule

// File: tb/tb_vga_fbuff_wr_ctrl.sv
// Directed bench for vga_fbuff_wr_ctrl with a 1-cycle-latency RAM model and
// scoreboard queues for frame-buffer writes and line-buffer read responses.
module tb_vga_fbuff_wr_ctrl;

  logic        clk = 1'b0;
  logic        rstn;
  logic        wr_valid_i;
  logic        wr_ready_o;
  logic [7:0]  wr_tile_x_i;
  logic [6:0]  wr_tile_y_i;
  logic [11:0] wr_colr_i;
  logic        wr_err_o;
  logic        lb_rd_req_i;
  logic [12:0] lb_addr_i;
  logic        lb_rd_rsp_o;
  logic [47:0] lb_data_o;
  logic [12:0] fbuff_addr_o;
  logic        fbuff_en_o;
  logic        fbuff_wen_o;
  logic [47:0] fbuff_data_o;
  logic [47:0] fbuff_data_i;

  logic [47:0] mem     [0:8191];
  logic [47:0] ref_mem [0:8191];
  logic [47:0] rd_q = '0;

  logic [63:0] wr_exp_q[$];
  logic [47:0] lb_exp_q[$];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  vga_fbuff_wr_ctrl dut (
    .clk          (clk),
    .rstn         (rstn),
    .wr_valid_i   (wr_valid_i),
    .wr_ready_o   (wr_ready_o),
    .wr_tile_x_i  (wr_tile_x_i),
    .wr_tile_y_i  (wr_tile_y_i),
    .wr_colr_i    (wr_colr_i),
    .wr_err_o     (wr_err_o),
    .lb_rd_req_i  (lb_rd_req_i),
    .lb_addr_i    (lb_addr_i),
    .lb_rd_rsp_o  (lb_rd_rsp_o),
    .lb_data_o    (lb_data_o),
    .fbuff_addr_o (fbuff_addr_o),
    .fbuff_en_o   (fbuff_en_o),
    .fbuff_wen_o  (fbuff_wen_o),
    .fbuff_data_o (fbuff_data_o),
    .fbuff_data_i (fbuff_data_i)
  );

  // Frame buffer port A: one cycle from enable to read data.
  always @(posedge clk) begin
    if (fbuff_en_o) begin
      if (fbuff_wen_o) mem[fbuff_addr_o] <= fbuff_data_o;
      else             rd_q <= mem[fbuff_addr_o];
    end
  end
  assign fbuff_data_i = rd_q;

  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic push_write(input int x, input int y, input logic [11:0] c);
    int row;
    int slot;
    row  = y * 40 + x / 4;
    slot = x % 4;
    ref_mem[row][slot*12 +: 12] = c;
    wr_exp_q.push_back({3'b000, 13'(row), ref_mem[row]});
  endtask

  task automatic apply_write(input int x, input int y, input logic [11:0] c);
    wr_valid_i  = 1'b1;
    wr_tile_x_i = 8'(x);
    wr_tile_y_i = 7'(y);
    wr_colr_i   = c;
  endtask

  task automatic wait_idle();
    logic found;
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      sample();
      if (wr_ready_o) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    check_output("wait_idle", {63'd0, found}, 64'd1);
  endtask

  // Scoreboard side: pops expectations whenever the DUT writes or responds.
  always @(negedge clk) begin : monitor
    logic [63:0] e;
    if (rstn && fbuff_en_o && fbuff_wen_o) begin
      if (wr_exp_q.size() == 0) begin
        check_output("unexpected_wr", 64'(wr_exp_q.size()), 64'd1);
      end else begin
        e = wr_exp_q.pop_front();
        check_output("fbuff_wr", {3'b000, fbuff_addr_o, fbuff_data_o}, e);
      end
    end
    if (lb_rd_rsp_o) begin
      if (lb_exp_q.size() == 0) begin
        check_output("unexpected_rsp", 64'(lb_exp_q.size()), 64'd1);
      end else begin
        e = {16'd0, lb_exp_q.pop_front()};
        check_output("lb_data", {16'd0, lb_data_o}, e);
      end
    end
  end

  initial begin
    rstn        = 1'b0;
    wr_valid_i  = 1'b0;
    wr_tile_x_i = '0;
    wr_tile_y_i = '0;
    wr_colr_i   = '0;
    lb_rd_req_i = 1'b0;
    lb_addr_i   = '0;
    for (int i = 0; i < 8192; i++) begin
      mem[i]     = '0;
      ref_mem[i] = '0;
    end
    mem[0]    = 48'h000_111_222_333;
    mem[40]   = 48'h40A_40B_40C_40D;
    mem[41]   = 48'h41A_41B_41C_41D;
    mem[4799] = 48'h123_456_789_ABC;
    ref_mem[0]    = mem[0];
    ref_mem[40]   = mem[40];
    ref_mem[41]   = mem[41];
    ref_mem[4799] = mem[4799];

    $display("[TB] reset state");
    repeat (3) tick();
    sample();
    check_output("rst_ready", {63'd0, wr_ready_o}, 64'd0);
    check_output("rst_en", {63'd0, fbuff_en_o}, 64'd0);
    check_output("rst_wen", {63'd0, fbuff_wen_o}, 64'd0);
    check_output("rst_rsp", {63'd0, lb_rd_rsp_o}, 64'd0);
    check_output("rst_err", {63'd0, wr_err_o}, 64'd0);
    check_output("rst_data", {16'd0, fbuff_data_o}, 64'd0);
    tick();
    rstn = 1'b1;
    sample();
    check_output("ready_after_rst", {63'd0, wr_ready_o}, 64'd1);

    $display("[TB] write x=2 y=0 into row 0");
    tick();
    push_write(2, 0, 12'hABC);
    apply_write(2, 0, 12'hABC);
    sample();
    check_output("t0_ready", {63'd0, wr_ready_o}, 64'd1);
    check_output("t0_en", {63'd0, fbuff_en_o}, 64'd0);
    tick();
    wr_valid_i = 1'b0;
    sample();
    check_output("t1_en", {63'd0, fbuff_en_o}, 64'd1);
    check_output("t1_wen", {63'd0, fbuff_wen_o}, 64'd0);
    check_output("t1_addr", {51'd0, fbuff_addr_o}, 64'd0);
    check_output("t1_ready", {63'd0, wr_ready_o}, 64'd0);
    tick();
    sample();
    check_output("t2_en", {63'd0, fbuff_en_o}, 64'd0);
    check_output("t2_ready", {63'd0, wr_ready_o}, 64'd0);
    tick();
    sample();
    check_output("t3_wen", {63'd0, fbuff_wen_o}, 64'd1);
    check_output("t3_data", {16'd0, fbuff_data_o}, {16'd0, 48'h000_ABC_222_333});
    check_output("t3_ready", {63'd0, wr_ready_o}, 64'd0);
    tick();
    sample();
    check_output("t4_ready", {63'd0, wr_ready_o}, 64'd1);
    check_output("t4_en", {63'd0, fbuff_en_o}, 64'd0);

    $display("[TB] write last tile x=159 y=119");
    tick();
    push_write(159, 119, 12'hF0F);
    apply_write(159, 119, 12'hF0F);
    sample();
    check_output("last_ready", {63'd0, wr_ready_o}, 64'd1);
    tick();
    wr_valid_i = 1'b0;
    wait_idle();
    check_output("data_hold", {16'd0, fbuff_data_o}, {16'd0, 48'hF0F_456_789_ABC});

    $display("[TB] out-of-range writes");
    tick();
    apply_write(160, 0, 12'h123);
    sample();
    check_output("oor_x_ready", {63'd0, wr_ready_o}, 64'd1);
    tick();
    wr_valid_i = 1'b0;
    sample();
    check_output("oor_x_err", {63'd0, wr_err_o}, 64'd1);
    check_output("oor_x_en", {63'd0, fbuff_en_o}, 64'd0);
    check_output("oor_x_ready_next", {63'd0, wr_ready_o}, 64'd1);
    tick();
    sample();
    check_output("oor_x_err_pulse", {63'd0, wr_err_o}, 64'd0);
    check_output("oor_x_en2", {63'd0, fbuff_en_o}, 64'd0);
    tick();
    apply_write(0, 120, 12'h456);
    sample();
    tick();
    wr_valid_i = 1'b0;
    sample();
    check_output("oor_y_err", {63'd0, wr_err_o}, 64'd1);
    check_output("oor_y_en", {63'd0, fbuff_en_o}, 64'd0);

    $display("[TB] simultaneous lb read and write");
    tick();
    lb_rd_req_i = 1'b1;
    lb_addr_i   = 13'd40;
    lb_exp_q.push_back(ref_mem[40]);
    push_write(1, 1, 12'h555);
    apply_write(1, 1, 12'h555);
    sample();
    check_output("sim_en", {63'd0, fbuff_en_o}, 64'd1);
    check_output("sim_wen", {63'd0, fbuff_wen_o}, 64'd0);
    check_output("sim_addr", {51'd0, fbuff_addr_o}, 64'd40);
    check_output("sim_ready", {63'd0, wr_ready_o}, 64'd0);
    tick();
    sample();
    check_output("sim_rsp", {63'd0, lb_rd_rsp_o}, 64'd1);
    check_output("sim_ready_wait", {63'd0, wr_ready_o}, 64'd0);
    tick();
    lb_rd_req_i = 1'b0;
    sample();
    check_output("sim_wr_accept", {63'd0, wr_ready_o}, 64'd1);
    tick();
    wr_valid_i = 1'b0;
    sample();
    check_output("sim_rmw_rd_en", {63'd0, fbuff_en_o}, 64'd1);
    check_output("sim_rmw_rd_addr", {51'd0, fbuff_addr_o}, 64'd40);
    wait_idle();

    $display("[TB] lb read stalled behind an RMW");
    tick();
    push_write(5, 1, 12'h777);
    apply_write(5, 1, 12'h777);
    sample();
    check_output("stall_t0_ready", {63'd0, wr_ready_o}, 64'd1);
    tick();
    wr_valid_i  = 1'b0;
    lb_rd_req_i = 1'b1;
    lb_addr_i   = 13'd41;
    lb_exp_q.push_back(ref_mem[41]);
    sample();
    check_output("stall_t1_addr", {51'd0, fbuff_addr_o}, 64'd41);
    check_output("stall_t1_wen", {63'd0, fbuff_wen_o}, 64'd0);
    check_output("stall_t1_rsp", {63'd0, lb_rd_rsp_o}, 64'd0);
    tick();
    sample();
    check_output("stall_t2_en", {63'd0, fbuff_en_o}, 64'd0);
    tick();
    sample();
    check_output("stall_t3_wen", {63'd0, fbuff_wen_o}, 64'd1);
    tick();
    sample();
    check_output("stall_t4_en", {63'd0, fbuff_en_o}, 64'd1);
    check_output("stall_t4_wen", {63'd0, fbuff_wen_o}, 64'd0);
    check_output("stall_t4_rsp", {63'd0, lb_rd_rsp_o}, 64'd0);
    tick();
    sample();
    check_output("stall_t5_rsp", {63'd0, lb_rd_rsp_o}, 64'd1);
    tick();
    lb_rd_req_i = 1'b0;
    sample();
    check_output("stall_t6_ready", {63'd0, wr_ready_o}, 64'd1);

    $display("[TB] reset during RMW_WAIT");
    tick();
    apply_write(4, 1, 12'h999);
    sample();
    tick();
    wr_valid_i = 1'b0;
    sample();
    check_output("abort_rd_en", {63'd0, fbuff_en_o}, 64'd1);
    tick();
    rstn = 1'b0;
    sample();
    check_output("abort_wen", {63'd0, fbuff_wen_o}, 64'd0);
    check_output("abort_ready", {63'd0, wr_ready_o}, 64'd0);
    check_output("abort_rsp", {63'd0, lb_rd_rsp_o}, 64'd0);
    check_output("abort_en", {63'd0, fbuff_en_o}, 64'd0);
    tick();
    tick();
    rstn = 1'b1;
    tick();
    lb_rd_req_i = 1'b1;
    lb_addr_i   = 13'd41;
    lb_exp_q.push_back(ref_mem[41]);
    sample();
    check_output("abort_lb_en", {63'd0, fbuff_en_o}, 64'd1);
    tick();
    sample();
    check_output("abort_lb_rsp", {63'd0, lb_rd_rsp_o}, 64'd1);
    tick();
    lb_rd_req_i = 1'b0;
    repeat (4) tick();

    check_output("wr_q_drained", 64'(wr_exp_q.size()), 64'd0);
    check_output("lb_q_drained", 64'(lb_exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
